// File: rtl/mips_dmem_wait.sv
// Data memory with a fixed number of wait states per access, one request in flight.
// Latency: done pulses LATENCY cycles after the accept edge (one request per LATENCY+2 cycles).
// Backpressure: ready is high only in IDLE; a req seen while ready=0 is dropped, never queued.
module mips_dmem_wait #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = 32 - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               lat_we;
  logic [31:0]        lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [NB-1:0]      lat_be;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   lat_idx;
  logic [MEM_AW-1:0]  mem_idx;
  logic               lat_bad;
  logic               accept;
  logic               commit;

  // Decode of the latched request; the memory index is only used when lat_bad=0.
  assign lat_idx = lat_addr[31:OFF_W];
  assign mem_idx = lat_idx[MEM_AW-1:0];
  assign lat_bad = (|lat_addr[OFF_W-1:0]) || (lat_idx >= IDX_W'(DEPTH));
  assign accept  = (state == IDLE) && req;
  assign commit  = (state == WAIT) && (cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE -> WAIT on accept, WAIT -> DONE when the counter expires.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req) next_state = WAIT;
      WAIT:    if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded purely from state.
  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Request capture and wait-state counter; inputs are sampled only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      cnt       <= CNT_W'(LATENCY - 1);
      lat_we    <= we;
      lat_addr  <= addr;
      lat_wdata <= wdata;
      lat_be    <= be;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Memory array: cleared by reset, byte-lane writes commit on the WAIT->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && lat_we && !lat_bad) begin
      for (int k = 0; k < NB; k++) begin
        if (lat_be[k]) mem[mem_idx][8*k +: 8] <= lat_wdata[8*k +: 8];
      end
    end
  end

  // Completion data: loaded on the commit edge, forced to zero in every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (commit) begin
      err   <= lat_bad;
      rdata <= (!lat_we && !lat_bad) ? mem[mem_idx] : '0;
    end else begin
      rdata <= '0;
      err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_dmem_wait.sv
// Scoreboard bench for mips_dmem_wait: directed cases plus random traffic.
// Expected completions come from a word-array model and are checked by a monitor.
// Junk requests are driven whenever the DUT is busy to show they are ignored.
module tb_mips_dmem_wait;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int LAT   = 3;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we  = 1'b0;
  logic [31:0]   addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] be = '0;
  logic          ready;
  logic          done;
  logic [DW-1:0] rdata;
  logic          err;

  always #5 clk = ~clk;

  mips_dmem_wait #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .ready(ready), .done(done),
    .rdata(rdata), .err(err)
  );

  typedef struct {
    bit            is_rd;
    bit            err;
    logic [DW-1:0] rdata;
    int            due;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  logic [DW-1:0] model [DEPTH];
  int            cyc = 0;
  int            busy_end = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour: one access applied to a plain word array.
  function automatic exp_t model_access(input bit w, input logic [31:0] a,
                                        input logic [DW-1:0] d, input logic [NB-1:0] b);
    exp_t e;
    int   idx;
    e.is_rd = !w;
    e.rdata = '0;
    e.due   = 0;
    e.err   = (a % NB != 0) || ((a / NB) >= DEPTH);
    if (!e.err) begin
      idx = int'(a / NB);
      if (w) begin
        for (int k = 0; k < NB; k++)
          if (b[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        e.rdata = model[idx];
      end
    end
    return e;
  endfunction

  // Present a request now; the DUT must be ready so it is accepted on the next edge.
  task automatic drive(input bit w, input logic [31:0] a, input logic [DW-1:0] d,
                       input logic [NB-1:0] b);
    exp_t e;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    e = model_access(w, a, d, b);
    e.due = cyc + 1 + LAT;
    q.push_back(e);
    busy_end = cyc + 2 + LAT;
  endtask

  // Wait (bounded) for ready, scribbling junk on the inputs meanwhile, then drive.
  task automatic issue(input bit w, input logic [31:0] a, input logic [DW-1:0] d,
                       input logic [NB-1:0] b);
    int t = 0;
    forever begin
      @(negedge clk); #1;
      if (ready) break;
      req = 1'($urandom); we = 1'($urandom); addr = $urandom;
      wdata = DW'($urandom); be = NB'($urandom);
      t++;
      if (t > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: ready=%0b after %0d cycles, required 1", ready, t);
        return;
      end
    end
    drive(w, a, d, b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      req = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || rdata !== '0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: ready=%b done=%b rdata=%h err=%b, required ready=1 done=0 rdata=0 err=0",
               name, ready, done, rdata, err);
    end
  endtask

  // Monitor: checks ready timing, quiet outputs, and every done against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (ready !== (cyc >= busy_end)) begin
        n_bad++;
        $display("FAIL ready: cyc=%0d got %b required %b", cyc, ready, (cyc >= busy_end));
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_done: cyc=%0d done=1, required no completion", cyc);
        end else begin
          mon_e = q.pop_front();
          n_cmp++;
          if (cyc != mon_e.due) begin
            n_bad++;
            $display("FAIL done_time: done at cyc %0d, required cyc %0d", cyc, mon_e.due);
          end
          n_cmp++;
          if (err !== mon_e.err) begin
            n_bad++;
            $display("FAIL err: got %b required %b (cyc %0d)", err, mon_e.err, cyc);
          end
          if (mon_e.is_rd || mon_e.err) begin
            n_cmp++;
            if (rdata !== mon_e.rdata) begin
              n_bad++;
              $display("FAIL rdata: got %h required %h (cyc %0d)", rdata, mon_e.rdata, cyc);
            end
          end
        end
      end else begin
        n_cmp++;
        if (rdata !== '0 || err !== 1'b0) begin
          n_bad++;
          $display("FAIL quiet_out: done=0 rdata=%h err=%b, required rdata=0 err=0", rdata, err);
        end
        if (q.size() > 0 && cyc > q[0].due) begin
          n_cmp++; n_bad++;
          $display("FAIL missing_done: no done by cyc %0d, required at cyc %0d", cyc, q[0].due);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    #1 check_reset_outputs("reset_state");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);      // accepted on first edge after reset
    issue(1'b0, 32'h8, '0, '0);

    issue(1'b1, 32'hC, 32'h11223344, 4'hF);
    issue(1'b1, 32'hC, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'hC, '0, '0);                   // 11BB33DD

    issue(1'b1, 32'h10, 32'h55667788, 4'h0);      // empty byte mask: no change, no error
    issue(1'b0, 32'h10, '0, '0);

    issue(1'b0, 32'h6, '0, '0);                   // misaligned
    issue(1'b1, 32'h80, 32'hFFFFFFFF, 4'hF);      // word 32 is out of range
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(i * 4), '0, '0);

    // Reset during WAIT abandons the in-flight write.
    issue(1'b1, 32'h4, 32'hCAFEF00D, 4'hF);
    @(negedge clk); #1;
    rst = 1'b1;
    #1 check_reset_outputs("reset_mid_op");
    q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    busy_end = 0;
    @(negedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 32'h4, '0, '0);                   // must read 0

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'($urandom_range(0, DEPTH * 4 + 15));
      else             a = 32'($urandom_range(0, DEPTH + 3) * 4);
      issue(1'($urandom), a, DW'($urandom), NB'($urandom));
    end

    idle(LAT + 4);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d completions outstanding, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
